// File: rtl/fp_pkg.sv
// Shared single-precision definitions for the floating-point multiply/divide datapaths.
package fp_pkg;

   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;
   localparam int BIAS     = 2**(FP_EXP_W-1) - 1;
   localparam int EXP_MAX  = 2**FP_EXP_W - 1;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef struct packed {
      logic                sign;
      logic [FP_EXP_W-1:0] exp;
      logic [FP_MAN_W-1:0] man;
   } f32_t;

   typedef enum logic [1:0] {IDLE, MUL, NORM} state_t;

   function automatic f32_t f32unpack(input logic [31:0] w);
      return f32_t'(w);
   endfunction

   function automatic logic [31:0] f32pack(input f32_t f);
      return 32'(f);
   endfunction

endpackage

// File: rtl/fpmul_mmul.sv
// Sequential radix-2 shift-add mantissa multiplier; one multiplier bit per clock.
module mmul #(
   parameter int MAN_W = 23
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [MAN_W:0]     a,
   input  logic [MAN_W:0]     b,
   output logic [2*MAN_W+1:0] p,
   output logic               fin
);
   localparam int N  = MAN_W + 1;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N);

   logic [CW-1:0]      cnt_q, cnt_d;
   logic [MAN_W:0]     a_q, b_q, b_d;
   logic [2*MAN_W+1:0] acc_q, acc_d;
   logic [MAN_W+1:0]   sum;

   assign fin = (cnt_q == LAST);
   assign p   = acc_q;

   // Carry of the high-half add drops into the MSB as the accumulator shifts right.
   always_comb begin
      sum   = {1'b0, acc_q[2*N-1:N]} + (b_q[0] ? {1'b0, a_q} : '0);
      acc_d = {sum, acc_q[N-1:1]};
      b_d   = b_q >> 1;
      cnt_d = cnt_q + 1'b1;
   end

   // Counter parks at LAST so the loop is idle until the next load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt_q <= LAST;
      else if (load)
         cnt_q <= '0;
      else if (!fin)
         cnt_q <= cnt_d;
   end

   always_ff @(posedge clk) begin
      if (load) begin
         a_q   <= a;
         b_q   <= b;
         acc_q <= '0;
      end else if (!fin) begin
         b_q   <= b_d;
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/fpmul.sv
// Iterative floating-point multiplier: shift-add mantissa product followed by one
// normalise/round/pack cycle. Subnormal operands and results flush to signed zero.
module fpmul
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [EXP_W+MAN_W:0] multiplicand,
   input  logic [EXP_W+MAN_W:0] multiplier,
   output logic [EXP_W+MAN_W:0] product,
   output logic                 busy,
   output logic                 done
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int N  = MAN_W + 1;
   localparam int EW = EXP_W + 2;
   localparam logic signed [EW-1:0] BIAS_E = EW'((1 << (EXP_W-1)) - 1);
   localparam logic signed [EW-1:0] EMAX_E = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] ZERO_E = EW'(0);
   localparam logic [W-1:0] QNAN_W = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   state_t                 state_q, state_d;
   logic [W-1:0]           a_q, b_q, prod_q, prod_d;
   logic                   done_q, load, fin;
   logic [2*N-1:0]         p, norm;
   logic [EXP_W-1:0]       ea, eb;
   logic [MAN_W-1:0]       ma, mb, man_o;
   logic                   sgn, za, zb, ia, ib, na, nb, guard, sticky;
   logic [N-1:0]           kept;
   logic [N:0]             rnd;
   logic signed [EW-1:0]   e_sum, e_norm, e_fin;

   assign load    = (state_q == IDLE) && start;
   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign product = prod_q;

   mmul #(.MAN_W(MAN_W)) u_mmul (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .a     ({1'b1, multiplicand[MAN_W-1:0]}),
      .b     ({1'b1, multiplier[MAN_W-1:0]}),
      .p     (p),
      .fin   (fin)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = MUL;
         MUL:     if (fin) state_d = NORM;
         NORM:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      {ea, ma} = a_q[W-2:0];
      {eb, mb} = b_q[W-2:0];
      sgn = a_q[W-1] ^ b_q[W-1];
      za  = (ea == '0);
      zb  = (eb == '0);
      ia  = (&ea) && (ma == '0);
      ib  = (&eb) && (mb == '0);
      na  = (&ea) && (ma != '0);
      nb  = (&eb) && (mb != '0);

      // Left-aligning a product below 2.0 puts guard and sticky at fixed positions.
      norm   = p[2*N-1] ? p : (p << 1);
      kept   = norm[2*N-1:N];
      guard  = norm[N-1];
      sticky = |norm[N-2:0];
      rnd    = {1'b0, kept} + (N+1)'(guard & (sticky | kept[0]));
      man_o  = rnd[N] ? rnd[N-1:1] : rnd[N-2:0];

      e_sum  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_E;
      e_norm = e_sum + $signed(EW'(p[2*N-1]));
      e_fin  = e_norm + $signed(EW'(rnd[N]));

      if (na || nb || (ia && zb) || (ib && za))
         prod_d = QNAN_W;
      else if (ia || ib)
         prod_d = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (za || zb)
         prod_d = {sgn, {(W-1){1'b0}}};
      else if (e_fin >= EMAX_E)
         prod_d = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (e_fin <= ZERO_E)
         prod_d = {sgn, {(W-1){1'b0}}};
      else
         prod_d = {sgn, e_fin[EXP_W-1:0], man_o};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         prod_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == NORM);
         if (state_q == NORM)
            prod_q <= prod_d;
      end
   end

   // Operands are held for the exponent and special-case decode in NORM.
   always_ff @(posedge clk) begin
      if (load) begin
         a_q <= multiplicand;
         b_q <= multiplier;
      end
   end

endmodule

// File: tb/tb_fpmul.sv
// Randomised and directed bench for fpmul against an exact-integer rounding model.
module tb_fpmul;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] multiplicand, multiplier, product;
   logic        busy, done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fpmul #(.EXP_W(8), .MAN_W(23)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .product      (product),
      .busy         (busy),
      .done         (done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Exact product of the significands, rounded to 24 bits by integer remainder.
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      int ea, eb, e, msb, sh;
      logic s;
      longint unsigned ma, mb, m, q, rem, half;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
          (ea == 255 && eb == 0) || (eb == 255 && ea == 0))
         return 32'h7FC0_0000;
      if (ea == 255 || eb == 255)
         return {s, 8'hFF, 23'h0};
      if (ea == 0 || eb == 0)
         return {s, 31'h0};
      ma = {40'd1, a[22:0]};
      mb = {40'd1, b[22:0]};
      m  = ma * mb;
      msb = 47;
      while (m[msb] == 1'b0) msb--;
      sh   = msb - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      e = ea + eb - 127 + (msb - 46);
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         e++;
      end
      if (e >= 255) return {s, 8'hFF, 23'h0};
      if (e <= 0)   return {s, 31'h0};
      return {s, e[7:0], q[22:0]};
   endfunction

   function automatic logic [31:0] rnd_op();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 9))
         0:       r[30:23] = 8'hFF;
         1:       r[30:23] = 8'h00;
         2:       r[30:23] = 8'($urandom_range(1, 8));
         3:       r[30:23] = 8'($urandom_range(240, 254));
         default: r[30:23] = 8'($urandom_range(64, 190));
      endcase
      if ($urandom_range(0, 5) == 0) r[22:0] = 23'h0;
      return r;
   endfunction

   // Waits for done, scrambling the operand inputs while the unit is busy.
   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clk);
         if (busy) begin
            multiplicand = rnd_op();
            multiplier   = rnd_op();
         end
         @(posedge clk);
         #1;
         n++;
      end while (!done && n < 40);
   endtask

   task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b);
      int n;
      @(negedge clk);
      multiplicand = a;
      multiplier   = b;
      start        = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk({tag, "/busy"}, {31'b0, busy}, 32'd1);
      wait_done(n);
      chk({tag, "/lat"}, n, 32'd26);
      chk({tag, "/prod"}, product, ref_mul(a, b));
      chk({tag, "/busy_at_done"}, {31'b0, busy}, 32'd0);
      @(posedge clk);
      #1;
      chk({tag, "/done_pulse"}, {31'b0, done}, 32'd0);
   endtask

   initial begin
      int n;
      logic [31:0] a1, b1;

      reset = 1'b1;
      start = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      #2 reset = 1'b0;
      #1;
      chk("rst/busy", {31'b0, busy}, 32'd0);
      chk("rst/done", {31'b0, done}, 32'd0);
      chk("rst/prod", product, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // Fixed expectations cross-check the reference model itself.
      chk("ref/1.5x2", ref_mul(32'h3FC0_0000, 32'h4000_0000), 32'h4040_0000);
      chk("ref/rne",   ref_mul(32'h3F80_0001, 32'h3F80_0001), 32'h3F80_0002);

      do_op("t1_1.5x2",   32'h3FC0_0000, 32'h4000_0000);
      chk("t1/value", product, 32'h4040_0000);
      do_op("t2_neg",     32'hC000_0000, 32'h3F00_0000);
      chk("t2/value", product, 32'hBF80_0000);
      do_op("t2_rne",     32'h3F80_0001, 32'h3F80_0001);
      do_op("t3_ovf",     32'h7F00_0000, 32'h4000_0000);
      chk("t3/ovf", product, 32'h7F80_0000);
      do_op("t3_unf",     32'h0080_0000, 32'h3F00_0000);
      chk("t3/unf", product, 32'h0000_0000);
      do_op("t3_unf_neg", 32'h8080_0000, 32'h3F00_0000);
      chk("t3/unf_neg", product, 32'h8000_0000);
      do_op("t4_infx0",   32'h7F80_0000, 32'h0000_0000);
      chk("t4/infx0", product, 32'h7FC0_0000);
      do_op("t4_ninf",    32'hFF80_0000, 32'h4000_0000);
      do_op("t4_nan",     32'h7FC0_0001, 32'h3F80_0000);
      do_op("rne_tie",    32'h3F80_0001, 32'h3FFF_FFFF);

      for (int i = 0; i < 30; i++)
         do_op($sformatf("rand%0d", i), rnd_op(), rnd_op());

      // Start held high throughout: only IDLE accepts sample the operands.
      @(negedge clk);
      a1 = rnd_op();
      b1 = rnd_op();
      multiplicand = a1;
      multiplier   = b1;
      start        = 1'b1;
      @(posedge clk);
      #1;
      for (int r = 0; r < 4; r++) begin
         wait_done(n);
         chk($sformatf("b2b%0d/lat", r), n, 32'd26);
         chk($sformatf("b2b%0d/prod", r), product, ref_mul(a1, b1));
         @(negedge clk);
         a1 = rnd_op();
         b1 = rnd_op();
         multiplicand = a1;
         multiplier   = b1;
         if (r == 3) start = 1'b0;
         @(posedge clk);
         #1;
         if (r < 3) chk($sformatf("b2b%0d/reaccept", r), {31'b0, busy}, 32'd1);
      end

      // Asynchronous reset in the middle of an operation.
      do_op("pre_rst", 32'h4040_0000, 32'h4040_0000);
      @(negedge clk);
      multiplicand = 32'h3FC0_0000;
      multiplier   = 32'h3FC0_0000;
      start        = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("arst/busy", {31'b0, busy}, 32'd0);
      chk("arst/done", {31'b0, done}, 32'd0);
      chk("arst/prod", product, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      do_op("post_rst", 32'h4010_0000, 32'hC0A0_0000);
      chk("post_rst/value", product, 32'hC134_0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
